// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync, de-glitch, deframe, check, hand off.
// Define PS2_RX_FIFO_EN for a 4-entry output FIFO; otherwise a single holding register.
module ps2_frame_rx #(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line index 0 is ps2clk, index 1 is ps2dat.
    logic [1:0]      raw;
    logic [1:0]      s1_q, s2_q, filt_q, flip;
    logic [1:0][3:0] cnt_q;

    logic            fall;
    logic            dat;

    state_t          state_q, state_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            bad_q, bad_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout;
    logic            commit;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    assign raw  = {ps2dat, ps2clk};
    assign fall = flip[0] & filt_q[0];
    assign dat  = filt_q[1];

    // A line flips only once it has disagreed with the filtered level long enough.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (s2_q[i] != filt_q[i]) &&
                      (cnt_q[i] == 4'(FILTER_LEN - 1));
        end
    end

    // Two-flop synchronisers and glitch filters for both pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            filt_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                s1_q[i] <= raw[i];
                s2_q[i] <= s1_q[i];
                if (s2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (flip[i]) begin
                    cnt_q[i]  <= '0;
                    filt_q[i] <= ~filt_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Frame FSM next state, inter-edge timeout and error pulse requests.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        bad_d   = bad_q;
        commit  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        tcnt_d  = (state_q == IDLE || fall) ? '0 : tcnt_q + 1'b1;
        timeout = (state_q != IDLE) && !fall &&
                  (tcnt_q == TW'(TO_CYC - 1));
        unique case (state_q)
            IDLE: begin
                if (fall && !dat) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    par_d   = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d = {dat, shift_q[7:1]};
                    par_d   = par_q ^ dat;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    bad_d   = ~(par_q ^ dat);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (!dat)       ferr_d = 1'b1;
                    else if (bad_q) perr_d = 1'b1;
                    else            commit = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    // FSM and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            bad_q   <= 1'b0;
            tcnt_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bad_q   <= bad_d;
            tcnt_q  <= tcnt_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PS2_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wp_q, rp_q;
    logic       full_q, empty_q;
    logic       wr;

    assign accept = !empty_q && out_ready;
    assign wr     = commit && (!full_q || accept);
    assign ovf_d  = commit && !wr;

    // FIFO storage; a same-cycle pop makes room for the push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= shift_q;
                wp_q        <= wp_q + 2'd1;
            end
            if (accept) rp_q <= rp_q + 2'd1;
            if (wr && !accept) begin
                empty_q <= 1'b0;
                full_q  <= (wp_q + 2'd1) == rp_q;
            end else if (accept && !wr) begin
                full_q  <= 1'b0;
                empty_q <= (rp_q + 2'd1) == wp_q;
            end
        end
    end

    assign out_data  = mem_q[rp_q];
    assign out_valid = !empty_q;
`else
    logic [7:0] data_q;
    logic       valid_q;

    assign accept = valid_q && out_ready;
    assign ovf_d  = commit && valid_q && !accept;

    // Single holding register; an accept in the same cycle frees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (commit && (!valid_q || accept)) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
`endif

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule
